ha_array_accumulator: RTL and testbench

- Downstream consumer of the unsigned 8x8 half-adder array stage.
- Captures the four (b, t) row-pair vectors in one handshake beat, then reduces them to a single product over four cycles, one group per cycle.
- Presents the result on a valid/ready output, giving the array stage a registered, back-pressurable final-sum stage.

---
 rtl/ha_acc_pkg.sv | 16 +
 rtl/ha_row_weight.sv | 16 +
 rtl/ha_array_accumulator.sv | 125 ++++++++++++
 tb/tb_ha_array_accumulator.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ha_acc_pkg.sv
// Shared constants and types for the half-adder array accumulator.
package ha_acc_pkg;

    localparam int NUM_GROUPS = 4;
    localparam int B_W        = 7;
    localparam int T_W        = 9;
    localparam int ACC_W      = 17;
    localparam int GRP_W      = $clog2(NUM_GROUPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ha_row_weight.sv
// Combinational row weighting: (t + 4*b) scaled by 4^grp_idx, zero-extended to ACC_W.
module ha_row_weight
    import ha_acc_pkg::*;
(
    input  logic [B_W-1:0]   b,
    input  logic [T_W-1:0]   t,
    input  logic [GRP_W-1:0] grp_idx,
    output logic [ACC_W-1:0] row
);

    logic [ACC_W-1:0] base;

    assign base = ACC_W'(t) + (ACC_W'(b) << 2);
    assign row  = base << {grp_idx, 1'b0};

endmodule

// File: rtl/ha_array_accumulator.sv
// Captures four (b, t) row-pair groups in one beat and sums them one group per cycle.
// Result held on a valid/ready output; no new capture until the product is taken.
module ha_array_accumulator
    import ha_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B_W-1:0]   ha_array_0_b,
    input  logic [T_W-1:0]   ha_array_0_t,
    input  logic [B_W-1:0]   ha_array_1_b,
    input  logic [T_W-1:0]   ha_array_1_t,
    input  logic [B_W-1:0]   ha_array_2_b,
    input  logic [T_W-1:0]   ha_array_2_t,
    input  logic [B_W-1:0]   ha_array_3_b,
    input  logic [T_W-1:0]   ha_array_3_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] prod
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   prod_q, prod_d;
    logic [GRP_W-1:0]   grp_idx_q, grp_idx_d;
    logic               out_valid_q, out_valid_d;
    logic [B_W-1:0]     b_q [NUM_GROUPS];
    logic [B_W-1:0]     b_d [NUM_GROUPS];
    logic [T_W-1:0]     t_q [NUM_GROUPS];
    logic [T_W-1:0]     t_d [NUM_GROUPS];

    logic [B_W-1:0]     b_sel;
    logic [T_W-1:0]     t_sel;
    logic [ACC_W-1:0]   row;
    logic [ACC_W-1:0]   sum;
    logic               last_grp;

    // Single weighting unit shared across groups through the captured-vector mux.
    assign b_sel = b_q[grp_idx_q];
    assign t_sel = t_q[grp_idx_q];

    ha_row_weight u_row_weight (
        .b       (b_sel),
        .t       (t_sel),
        .grp_idx (grp_idx_q),
        .row     (row)
    );

    assign sum       = acc_q + row;
    assign last_grp  = (grp_idx_q == GRP_W'(NUM_GROUPS - 1));
    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign prod      = prod_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        grp_idx_d   = grp_idx_q;
        out_valid_d = out_valid_q;
        b_d         = b_q;
        t_d         = t_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    b_d[0]    = ha_array_0_b;
                    t_d[0]    = ha_array_0_t;
                    b_d[1]    = ha_array_1_b;
                    t_d[1]    = ha_array_1_t;
                    b_d[2]    = ha_array_2_b;
                    t_d[2]    = ha_array_2_t;
                    b_d[3]    = ha_array_3_b;
                    t_d[3]    = ha_array_3_t;
                    acc_d     = '0;
                    grp_idx_d = '0;
                    state_d   = ACC;
                end
            end
            ACC: begin
                acc_d = sum;
                // Index holds on the last group so it never wraps.
                if (last_grp) begin
                    prod_d      = sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    grp_idx_d = grp_idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            prod_q      <= '0;
            grp_idx_q   <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_GROUPS; i++) begin
                b_q[i] <= '0;
                t_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            grp_idx_q   <= grp_idx_d;
            out_valid_q <= out_valid_d;
            b_q         <= b_d;
            t_q         <= t_d;
        end
    end

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Directed and randomized checks of the half-adder array accumulator.
module tb_ha_array_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  b_in [4];
    logic [8:0]  t_in [4];
    logic        out_valid;
    logic        out_ready;
    logic [16:0] prod;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ha_array_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (b_in[0]),
        .ha_array_0_t (t_in[0]),
        .ha_array_1_b (b_in[1]),
        .ha_array_1_t (t_in[1]),
        .ha_array_2_b (b_in[2]),
        .ha_array_2_t (t_in[2]),
        .ha_array_3_b (b_in[3]),
        .ha_array_3_t (t_in[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .prod         (prod)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_vec();
        for (int i = 0; i < 4; i++) begin
            b_in[i] = '0;
            t_in[i] = '0;
        end
    endtask

    // Reference: sum over groups of (t + 4*b) * 4^i.
    function automatic int unsigned ref_prod();
        int unsigned s;
        int unsigned w;
        s = 0;
        w = 1;
        for (int i = 0; i < 4; i++) begin
            s = s + (int'(t_in[i]) + 4 * int'(b_in[i])) * w;
            w = w * 4;
        end
        return s;
    endfunction

    task automatic capture_beat();
        int w;
        w = 0;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        clear_vec();
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (prod !== 17'd0) begin errors++; $display("FAIL reset_prod got=%0d exp=0", prod); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_zero();
        int n;
        clear_vec();
        out_ready = 1'b1;
        capture_beat();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_busy_in_ready got=%b exp=0", in_ready); end
        wait_valid(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL zero_latency got=%0d exp=4", n); end
        checks++;
        if (prod !== 17'd0) begin errors++; $display("FAIL zero_prod got=%0d exp=0", prod); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid_drop got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready_back got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_bits();
        int n;
        clear_vec();
        t_in[0] = 9'h001;
        capture_beat();
        wait_valid(n);
        checks++;
        if (prod !== 17'd1) begin errors++; $display("FAIL t0_lsb_prod got=%0d exp=1", prod); end
        tick();
        clear_vec();
        b_in[3] = 7'h40;
        capture_beat();
        wait_valid(n);
        checks++;
        if (prod !== 17'd16384) begin errors++; $display("FAIL b3_msb_prod got=%0d exp=16384", prod); end
        tick();
    endtask

    task automatic test_all_ones();
        int n;
        for (int i = 0; i < 4; i++) begin
            b_in[i] = 7'h7F;
            t_in[i] = 9'h1FF;
        end
        capture_beat();
        wait_valid(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL ones_latency got=%0d exp=4", n); end
        checks++;
        if (prod !== 17'h15257) begin errors++; $display("FAIL ones_prod got=%0d exp=86615", prod); end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        logic quiet;
        clear_vec();
        t_in[2] = 9'h005;
        out_ready = 1'b0;
        capture_beat();
        wait_valid(n);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || prod !== 17'd80 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d valid=%b prod=%0d in_ready=%b exp valid=1 prod=80 in_ready=0",
                         c, out_valid, prod, in_ready);
            end
            for (int i = 0; i < 4; i++) begin
                b_in[i] = 7'h7F;
                t_in[i] = 9'h1FF;
            end
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin errors++; $display("FAIL bp_no_queued_beat got=%b exp=1", quiet); end
    endtask

    task automatic test_reset_mid_acc();
        int n;
        for (int i = 0; i < 4; i++) begin
            b_in[i] = 7'h7F;
            t_in[i] = 9'h1FF;
        end
        capture_beat();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_acc_valid got=%b exp=0", out_valid); end
        checks++;
        if (prod !== 17'd0) begin errors++; $display("FAIL rst_acc_prod got=%0d exp=0", prod); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_acc_in_ready got=%b exp=1", in_ready); end
        clear_vec();
        t_in[1] = 9'h003;
        capture_beat();
        wait_valid(n);
        checks++;
        if (prod !== 17'd12) begin errors++; $display("FAIL rst_next_prod got=%0d exp=12", prod); end
        checks++;
        if (n != 4) begin errors++; $display("FAIL rst_next_latency got=%0d exp=4", n); end
        tick();
    endtask

    task automatic test_back_to_back();
        int unsigned exp_q[$];
        int unsigned exp;
        int sent;
        int got;
        int cyc;
        logic cap;
        sent = 0;
        got = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (got < 1000 && cyc < 40000) begin
            if (!in_valid && sent < 1000 && $urandom_range(3) != 0) begin
                for (int i = 0; i < 4; i++) begin
                    b_in[i] = 7'($urandom);
                    t_in[i] = 9'($urandom);
                end
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(1));
            cap = in_valid && in_ready;
            if (cap) begin
                exp_q.push_back(ref_prod());
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_output got=%0d exp=none", prod);
                end else begin
                    exp = exp_q.pop_front();
                    if (prod !== 17'(exp)) begin
                        errors++;
                        $display("FAIL b2b_prod beat=%0d got=%0d exp=%0d", got, prod, exp);
                    end
                end
                got++;
            end
            tick();
            cyc++;
            if (cap) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 1000) begin errors++; $display("FAIL b2b_received got=%0d exp=1000", got); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single_bits();
        test_all_ones();
        test_backpressure();
        test_reset_mid_acc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
